// File: rtl/bsg_cache_nb_pkg.sv
// bsg_cache_nb_pkg: shared store-buffer entry declaration for the non-blocking cache
`ifndef BSG_CACHE_NB_PKG_MACROS
`define BSG_CACHE_NB_PKG_MACROS
`define BSG_CACHE_NB_SBUF_ENTRY_WIDTH(addr_width_mp, word_width_mp, ways_mp) \
  ((addr_width_mp) + (word_width_mp) + ((word_width_mp) / 8) + $clog2(ways_mp))
`define DECLARE_BSG_CACHE_NB_SBUF_ENTRY_S(addr_width_mp, word_width_mp, ways_mp) \
  typedef struct packed { \
    logic [(addr_width_mp)-1:0] addr; \
    logic [(word_width_mp)-1:0] data; \
    logic [((word_width_mp)/8)-1:0] mask; \
    logic [$clog2(ways_mp)-1:0] way_id; \
  } bsg_cache_nb_sbuf_entry_s
`endif

package bsg_cache_nb_pkg;
  localparam int byte_width_lp = 8;
endpackage

// File: rtl/bsg_decode_with_v.sv
// bsg_decode_with_v: binary to one-hot decoder gated by a valid bit
// Ports: i binary index, v_i enable, o one-hot output (all zero when v_i=0).
module bsg_decode_with_v #(
  parameter int num_out_p = 8,
  localparam int lg_lp = $clog2(num_out_p)
) (
  input  logic [lg_lp-1:0]     i,
  input  logic                 v_i,
  output logic [num_out_p-1:0] o
);
  assign o = v_i ? {{(num_out_p-1){1'b0}}, 1'b1} << i : '0;
endmodule

// File: rtl/bsg_mux_segmented.sv
// bsg_mux_segmented: per-segment 2:1 mux, segment g taken from data1_i when sel_i[g]=1
// Ports: data0_i/data1_i inputs, sel_i one select bit per segment, data_o result.
module bsg_mux_segmented #(
  parameter int segments_p = 4,
  parameter int segment_width_p = 8
) (
  input  logic [segments_p*segment_width_p-1:0] data0_i,
  input  logic [segments_p*segment_width_p-1:0] data1_i,
  input  logic [segments_p-1:0]                 sel_i,
  output logic [segments_p*segment_width_p-1:0] data_o
);
  for (genvar g = 0; g < segments_p; g++) begin : seg
    assign data_o[g*segment_width_p+:segment_width_p] = sel_i[g]
      ? data1_i[g*segment_width_p+:segment_width_p]
      : data0_i[g*segment_width_p+:segment_width_p];
  end
endmodule

// File: rtl/bsg_cache_nb_sbuf_drain.sv
// bsg_cache_nb_sbuf_drain: drains store-buffer entries into byte-masked data-memory writes
module bsg_cache_nb_sbuf_drain
  import bsg_cache_nb_pkg::*;
#(
  parameter int word_width_p = 32,
  parameter int addr_width_p = 32,
  parameter int ways_p = 8,
  parameter int sets_p = 64,
  parameter int block_size_in_words_p = 8,
  localparam int wm_lp = word_width_p / byte_width_lp,
  localparam int lg_wm_lp = $clog2(wm_lp),
  localparam int lg_bw_lp = $clog2(block_size_in_words_p),
  localparam int lg_sets_lp = $clog2(sets_p),
  localparam int lg_ways_lp = $clog2(ways_p),
  localparam int entry_width_lp = `BSG_CACHE_NB_SBUF_ENTRY_WIDTH(addr_width_p, word_width_p, ways_p)
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [entry_width_lp-1:0]      sbuf_entry_i,
  input  logic                           sbuf_v_i,
  output logic                           sbuf_yumi_o,
  output logic                           data_mem_v_o,
  output logic [lg_sets_lp+lg_bw_lp-1:0] data_mem_addr_o,
  output logic [ways_p*word_width_p-1:0] data_mem_data_o,
  output logic [ways_p*wm_lp-1:0]        data_mem_w_mask_o,
  input  logic                           data_mem_yumi_i,
  input  logic                           evict_v_i,
  input  logic [lg_sets_lp-1:0]          evict_index_i,
  input  logic [lg_ways_lp-1:0]          evict_way_i,
  output logic                           empty_o,
  output logic [15:0]                    retire_count_o
);
  `DECLARE_BSG_CACHE_NB_SBUF_ENTRY_S(addr_width_p, word_width_p, ways_p);
  bsg_cache_nb_sbuf_entry_s entry, hold_r, hold_n, merged;
  logic hold_v_r, hold_v_n;
  logic [15:0] retire_r;
  logic blocked, grant, match, load, merge;
  logic [word_width_p-1:0] merged_data;
  logic [ways_p-1:0] way_dec;
  assign entry = sbuf_entry_i;
  assign blocked = hold_v_r & evict_v_i
    & (evict_index_i == hold_r.addr[lg_wm_lp+lg_bw_lp+:lg_sets_lp])
    & (evict_way_i == hold_r.way_id);
  assign data_mem_v_o = hold_v_r & ~blocked;
  assign grant = data_mem_v_o & data_mem_yumi_i;
  assign match = hold_v_r & sbuf_v_i
    & (entry.addr[addr_width_p-1:lg_wm_lp] == hold_r.addr[addr_width_p-1:lg_wm_lp])
    & (entry.way_id == hold_r.way_id);
  assign load = (~hold_v_r | grant) & sbuf_v_i;
  assign merge = match & ~grant;
  assign sbuf_yumi_o = sbuf_v_i & (~hold_v_r | grant | merge);
  bsg_mux_segmented #(
    .segments_p(wm_lp),
    .segment_width_p(byte_width_lp)
  ) merge_mux (
    .data0_i(hold_r.data),
    .data1_i(entry.data),
    .sel_i(entry.mask),
    .data_o(merged_data)
  );
  always_comb begin
    merged = hold_r;
    merged.data = merged_data;
    merged.mask = hold_r.mask | entry.mask;
    hold_n = load ? entry : merge ? merged : hold_r;
    hold_v_n = load | (hold_v_r & ~grant);
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      hold_v_r <= 1'b0;
      hold_r <= '0;
      retire_r <= '0;
    end else begin
      hold_v_r <= hold_v_n;
      hold_r <= hold_n;
      retire_r <= retire_r + 16'(grant);
    end
  bsg_decode_with_v #(
    .num_out_p(ways_p)
  ) way_decode (
    .i(hold_r.way_id),
    .v_i(hold_v_r),
    .o(way_dec)
  );
  for (genvar g = 0; g < ways_p; g++) begin : slot
    assign data_mem_w_mask_o[g*wm_lp+:wm_lp] = way_dec[g] ? hold_r.mask : '0;
  end
  assign data_mem_data_o = {ways_p{hold_r.data}};
  assign data_mem_addr_o = hold_r.addr[lg_wm_lp+lg_bw_lp+lg_sets_lp-1:lg_wm_lp];
  assign empty_o = ~hold_v_r;
  assign retire_count_o = retire_r;
endmodule
